snoop_bus_arbiter: RTL and testbench

- Shares one downstream snoop-transmit/response channel pair (sdt/sdr) between NUM_REQ cache controllers.
- Grants one requester at a time, round-robin, and holds the grant from sdt acceptance until the matching sdr response is delivered back.
- Sits between the per-cache sdt/sdr ports and the shared memory/bus side; exactly one transaction is outstanding at a time.

---
 rtl/snoop_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter
// Purpose  : Round-robin arbiter that shares one sdt/sdr channel pair across
//            NUM_REQ caches. Optional macro SNOOP_ARB_TIMEOUT_EN adds a
//            response timeout and a sticky timeout_err output.
// Revision : 1.0
// ============================================================================
module snoop_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SADDR_WIDTH    = 26,
    parameter int BLK_WIDTH      = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_sdt_valid,
    output logic [NUM_REQ-1:0]                 req_sdt_ready,
    input  logic [3*NUM_REQ-1:0]               req_sdt_op,
    input  logic [SADDR_WIDTH*NUM_REQ-1:0]     req_sdt_addr,
    input  logic [BLK_WIDTH*NUM_REQ-1:0]       req_sdt_data,
    output logic [NUM_REQ-1:0]                 req_sdr_valid,
    input  logic [NUM_REQ-1:0]                 req_sdr_ready,
    output logic [2:0]                         req_sdr_rsp,
    output logic [BLK_WIDTH-1:0]               req_sdr_data,
    output logic                               mem_sdt_valid,
    input  logic                               mem_sdt_ready,
    output logic [2:0]                         mem_sdt_op,
    output logic [SADDR_WIDTH-1:0]             mem_sdt_addr,
    output logic [BLK_WIDTH-1:0]               mem_sdt_data,
    input  logic                               mem_sdr_valid,
    output logic                               mem_sdr_ready,
    input  logic [2:0]                         mem_sdr_rsp,
    input  logic [BLK_WIDTH-1:0]               mem_sdr_data,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
`ifdef SNOOP_ARB_TIMEOUT_EN
    output logic                               busy,
    output logic                               timeout_err
`else
    output logic                               busy
`endif
);

    localparam int             c_GW   = $clog2(NUM_REQ);
    localparam logic [c_GW:0]  c_NUM  = (c_GW+1)'(NUM_REQ);
    localparam logic [c_GW-1:0] c_LAST = c_GW'(NUM_REQ-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   r_rr;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_any;
    logic [c_GW-1:0]      w_off;
    logic [c_GW:0]        w_sum;
    logic [c_GW-1:0]      w_pick;
    logic [c_GW-1:0]      w_rr_next;
    logic                 w_gvalid;
    logic                 w_rsp_done;
    logic                 w_tmo;

    // Rotate the request vector so the rr pointer sits at bit 0, then take
    // the lowest set bit and rotate the offset back into a requester index.
    always_comb begin
        w_dbl = {req_sdt_valid, req_sdt_valid} >> r_rr;
        w_rot = w_dbl[NUM_REQ-1:0];
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = c_GW'(k);
            end
        end
        w_sum = {1'b0, r_rr} + {1'b0, w_off};
        if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
        end
        w_pick = w_sum[c_GW-1:0];
    end

    assign w_rr_next  = (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
    assign w_gvalid   = req_sdt_valid[r_grant];
    assign w_rsp_done = req_sdr_valid[r_grant] && req_sdr_ready[r_grant];

`ifdef SNOOP_ARB_TIMEOUT_EN
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_cnt;
    logic        r_tmo_err;
    assign w_tmo       = (r_state == S_WAIT) && (r_cnt >= c_TMO_LAST);
    assign timeout_err = r_tmo_err;
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        req_sdt_ready = '0;
        mem_sdt_valid = 1'b0;
        mem_sdt_op    = '0;
        mem_sdt_addr  = '0;
        mem_sdt_data  = '0;
        req_sdr_valid = '0;
        mem_sdr_ready = 1'b0;
        req_sdr_rsp   = '0;
        req_sdr_data  = '0;
        if (r_state == S_REQ) begin
            mem_sdt_valid          = w_gvalid;
            mem_sdt_op             = req_sdt_op[r_grant*3 +: 3];
            mem_sdt_addr           = req_sdt_addr[r_grant*SADDR_WIDTH +: SADDR_WIDTH];
            mem_sdt_data           = req_sdt_data[r_grant*BLK_WIDTH +: BLK_WIDTH];
            req_sdt_ready[r_grant] = mem_sdt_ready;
        end
        if (r_state == S_WAIT) begin
            if (w_tmo) begin
                // Synthesized error response; the memory side is ignored.
                req_sdr_valid[r_grant] = 1'b1;
                req_sdr_rsp            = 3'b111;
            end else begin
                req_sdr_valid[r_grant] = mem_sdr_valid;
                mem_sdr_ready          = req_sdr_ready[r_grant];
                req_sdr_rsp            = mem_sdr_rsp;
                req_sdr_data           = mem_sdr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_rr    <= '0;
`ifdef SNOOP_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!w_gvalid) begin
                        r_state <= S_IDLE;
                    end else if (mem_sdt_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_rsp_done) begin
                        r_rr    <= w_rr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef SNOOP_ARB_TIMEOUT_EN
            if (r_state == S_WAIT && !w_rsp_done && !w_tmo) begin
                r_cnt <= r_cnt + 32'd1;
            end else if (r_state != S_WAIT || w_rsp_done) begin
                r_cnt <= '0;
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end
`endif
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_bus_arbiter
// Purpose  : Table-driven grant-order vectors with a request/response
//            scoreboard, plus backpressure, protocol-drop, reset and timeout.
// Revision : 1.0
// ============================================================================
module tb_snoop_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 26;
    localparam int DW  = 64;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_sdt_valid;
    logic [N-1:0]    req_sdt_ready;
    logic [3*N-1:0]  req_sdt_op;
    logic [AW*N-1:0] req_sdt_addr;
    logic [DW*N-1:0] req_sdt_data;
    logic [N-1:0]    req_sdr_valid;
    logic [N-1:0]    req_sdr_ready;
    logic [2:0]      req_sdr_rsp;
    logic [DW-1:0]   req_sdr_data;
    logic            mem_sdt_valid;
    logic            mem_sdt_ready;
    logic [2:0]      mem_sdt_op;
    logic [AW-1:0]   mem_sdt_addr;
    logic [DW-1:0]   mem_sdt_data;
    logic            mem_sdr_valid;
    logic            mem_sdr_ready;
    logic [2:0]      mem_sdr_rsp;
    logic [DW-1:0]   mem_sdr_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef SNOOP_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    always #5 clk = ~clk;

    snoop_bus_arbiter #(
        .NUM_REQ(N), .SADDR_WIDTH(AW), .BLK_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_sdt_valid(req_sdt_valid), .req_sdt_ready(req_sdt_ready),
        .req_sdt_op(req_sdt_op), .req_sdt_addr(req_sdt_addr), .req_sdt_data(req_sdt_data),
        .req_sdr_valid(req_sdr_valid), .req_sdr_ready(req_sdr_ready),
        .req_sdr_rsp(req_sdr_rsp), .req_sdr_data(req_sdr_data),
        .mem_sdt_valid(mem_sdt_valid), .mem_sdt_ready(mem_sdt_ready),
        .mem_sdt_op(mem_sdt_op), .mem_sdt_addr(mem_sdt_addr), .mem_sdt_data(mem_sdt_data),
        .mem_sdr_valid(mem_sdr_valid), .mem_sdr_ready(mem_sdr_ready),
        .mem_sdr_rsp(mem_sdr_rsp), .mem_sdr_data(mem_sdr_data),
        .grant_id(grant_id),
`ifdef SNOOP_ARB_TIMEOUT_EN
        .busy(busy),
        .timeout_err(timeout_err)
`else
        .busy(busy)
`endif
    );

    typedef struct {
        logic [1:0]    id;
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sdt_exp_t;

    typedef struct {
        logic [1:0]    id;
        logic [2:0]    rsp;
        logic [DW-1:0] data;
    } sdr_exp_t;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] grant;
        int         hold;
    } vec_t;

    sdt_exp_t q_sdt[$];
    sdr_exp_t q_sdr[$];
    sdt_exp_t m_sdt;
    sdr_exp_t m_sdr;
    vec_t     tbl[13];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pops an expectation whenever a handshake completes.
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) begin
                chk("idle_quiet", {54'd0, mem_sdt_valid, mem_sdr_ready, req_sdt_ready, req_sdr_valid}, 64'd0);
            end
            if (mem_sdt_valid) begin
                chk("req_no_rsp_ready", {63'd0, mem_sdr_ready}, 64'd0);
            end
            chk("ready_onehot", {60'd0, req_sdt_ready & ~(4'b0001 << grant_id)}, 64'd0);
            if (mem_sdt_valid && mem_sdt_ready) begin
                if (q_sdt.size() == 0) begin
                    chk("sdt_unexpected", 64'd1, 64'd0);
                end else begin
                    m_sdt = q_sdt.pop_front();
                    chk("sdt_grant", {62'd0, grant_id}, {62'd0, m_sdt.id});
                    chk("sdt_ready", {60'd0, req_sdt_ready}, {60'd0, 4'b0001 << m_sdt.id});
                    chk("sdt_op", {61'd0, mem_sdt_op}, {61'd0, m_sdt.op});
                    chk("sdt_addr", {38'd0, mem_sdt_addr}, {38'd0, m_sdt.addr});
                    chk("sdt_data", mem_sdt_data, m_sdt.data);
                end
            end
            if (|(req_sdr_valid & req_sdr_ready)) begin
                if (q_sdr.size() == 0) begin
                    chk("sdr_unexpected", 64'd1, 64'd0);
                end else begin
                    m_sdr = q_sdr.pop_front();
                    chk("sdr_valid", {60'd0, req_sdr_valid}, {60'd0, 4'b0001 << m_sdr.id});
                    chk("sdr_rsp", {61'd0, req_sdr_rsp}, {61'd0, m_sdr.rsp});
                    chk("sdr_data", req_sdr_data, m_sdr.data);
                end
            end
        end
    end

    task automatic run_txn(input logic [3:0] mask, input logic [1:0] g, input int hold);
        logic [2:0]    rsp;
        logic [DW-1:0] rd;
        int            held;
        int            nbusy;
        bit            done;
        held  = 0;
        nbusy = 0;
        done  = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_sdt_op[3*i +: 3]    = 3'($urandom);
            req_sdt_addr[AW*i +: AW] = AW'($urandom);
            req_sdt_data[DW*i +: DW] = {$urandom, $urandom};
        end
        rsp = 3'($urandom);
        rd  = {$urandom, $urandom};
        q_sdt.push_back('{id: g, op: req_sdt_op[3*g +: 3], addr: req_sdt_addr[AW*g +: AW],
                          data: req_sdt_data[DW*g +: DW]});
        q_sdr.push_back('{id: g, rsp: rsp, data: rd});
        mem_sdr_rsp   = rsp;
        mem_sdr_data  = rd;
        mem_sdr_valid = 1'b1;
        req_sdr_ready = '1;
        mem_sdt_ready = (hold == 0);
        req_sdt_valid = mask;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (mem_sdt_valid && !mem_sdt_ready) begin
                held++;
                chk("hold_ready", {60'd0, req_sdt_ready}, 64'd0);
                chk("hold_addr", {38'd0, mem_sdt_addr}, {38'd0, req_sdt_addr[AW*g +: AW]});
                chk("hold_op", {61'd0, mem_sdt_op}, {61'd0, req_sdt_op[3*g +: 3]});
            end
            if (|(req_sdr_valid & req_sdr_ready)) done = 1'b1;
            @(posedge clk);
            #2;
            if (held >= hold) mem_sdt_ready = 1'b1;
        end
        chk("txn_done", {63'd0, done}, 64'd1);
        chk("busy_cycles", 64'(nbusy), 64'(2 + hold));
        chk("held_cycles", 64'(held), 64'(hold));
        req_sdt_valid = '0;
        mem_sdr_valid = 1'b0;
        mem_sdt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        int wc;
        rst = 1'b1;
        req_sdt_valid = '0; req_sdt_op = '0; req_sdt_addr = '0; req_sdt_data = '0;
        req_sdr_ready = '0; mem_sdt_ready = 1'b0; mem_sdr_valid = 1'b0;
        mem_sdr_rsp = '0; mem_sdr_data = '0;
        #3;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant", {62'd0, grant_id}, 64'd0);
        chk("rst_hs", {54'd0, mem_sdt_valid, mem_sdr_ready, req_sdt_ready, req_sdr_valid}, 64'd0);
        chk("rst_payload", {mem_sdt_op, mem_sdt_addr} | 64'(mem_sdt_data), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Response offered while idle must be neither accepted nor forwarded.
        mem_sdr_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_sdr_ready", {63'd0, mem_sdr_ready}, 64'd0);
            chk("idle_sdr_valid", {60'd0, req_sdr_valid}, 64'd0);
        end
        @(posedge clk); #2;
        mem_sdr_valid = 1'b0;

        tbl[0]  = '{4'b1111, 2'd0, 0};
        tbl[1]  = '{4'b1111, 2'd1, 0};
        tbl[2]  = '{4'b1111, 2'd2, 0};
        tbl[3]  = '{4'b1111, 2'd3, 0};
        tbl[4]  = '{4'b1111, 2'd0, 0};
        tbl[5]  = '{4'b0100, 2'd2, 0};
        tbl[6]  = '{4'b0001, 2'd0, 0};
        tbl[7]  = '{4'b0001, 2'd0, 0};
        tbl[8]  = '{4'b1010, 2'd1, 0};
        tbl[9]  = '{4'b1010, 2'd3, 0};
        tbl[10] = '{4'b0110, 2'd1, 0};
        tbl[11] = '{4'b1001, 2'd3, 0};
        tbl[12] = '{4'b0010, 2'd1, 5};
        for (int r = 0; r < 13; r++) begin
            run_txn(tbl[r].mask, tbl[r].grant, tbl[r].hold);
        end

        // Requester 0 drops valid before acceptance (pointer now at 2).
        mem_sdt_ready = 1'b0;
        req_sdt_valid = 4'b0001;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (mem_sdt_valid) hit = 1'b1;
        end
        chk("drop_reach", {63'd0, hit}, 64'd1);
        chk("drop_grant", {62'd0, grant_id}, 64'd0);
        @(posedge clk); #2;
        req_sdt_valid = '0;
        #1;
        chk("drop_valid", {63'd0, mem_sdt_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("drop_idle", {63'd0, busy}, 64'd0);

        // Reset while waiting for a response.
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) req_sdt_addr[AW*i +: AW] = AW'($urandom);
        q_sdt.push_back('{id: 2'd2, op: req_sdt_op[8:6], addr: req_sdt_addr[AW*2 +: AW],
                          data: req_sdt_data[DW*2 +: DW]});
        mem_sdt_ready = 1'b1;
        mem_sdr_valid = 1'b0;
        req_sdr_ready = '1;
        req_sdt_valid = 4'b0100;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (busy && !mem_sdt_valid) hit = 1'b1;
        end
        chk("wait_reach", {63'd0, hit}, 64'd1);
        chk("wait_sdr_ready", {63'd0, mem_sdr_ready}, 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        req_sdt_valid = '0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_grant", {62'd0, grant_id}, 64'd0);
        chk("mid_rst_hs", {54'd0, mem_sdt_valid, mem_sdr_ready, req_sdt_ready, req_sdr_valid}, 64'd0);
        chk("mid_rst_addr", {38'd0, mem_sdt_addr}, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        run_txn(4'b1000, 2'd3, 0);

`ifdef SNOOP_ARB_TIMEOUT_EN
        chk("tmo_err_clear", {63'd0, timeout_err}, 64'd0);
        q_sdt.push_back('{id: 2'd1, op: req_sdt_op[5:3], addr: req_sdt_addr[AW*1 +: AW],
                          data: req_sdt_data[DW*1 +: DW]});
        q_sdr.push_back('{id: 2'd1, rsp: 3'b111, data: '0});
        mem_sdr_data  = {$urandom, $urandom};
        mem_sdr_valid = 1'b0;
        mem_sdt_ready = 1'b1;
        req_sdr_ready = '1;
        req_sdt_valid = 4'b0010;
        hit = 1'b0;
        wc  = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (busy && !mem_sdt_valid) wc++;
            if (req_sdr_valid != '0) begin
                hit = 1'b1;
                chk("tmo_cycle", 64'(wc), 64'(TMO));
                chk("tmo_mem_ready", {63'd0, mem_sdr_ready}, 64'd0);
            end
        end
        chk("tmo_seen", {63'd0, hit}, 64'd1);
        @(posedge clk); #2;
        req_sdt_valid = '0;
        @(negedge clk);
        chk("tmo_idle", {63'd0, busy}, 64'd0);
        chk("tmo_err_set", {63'd0, timeout_err}, 64'd1);
`endif

        @(posedge clk); #2;
        chk("sb_drain", 64'(q_sdt.size() + q_sdr.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
